// File: rtl/pdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_pkg
//  Description : Shared constants and capture-state encoding for the PDM
//                capture memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package pdm_pkg;

  localparam int PDM_DEPTH = 49152;  // capture length in words
  localparam int PDM_AW    = 16;     // memory address width
  localparam int PDM_DW    = 32;     // data word width

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } pdm_state_e;

endpackage : pdm_pkg
`default_nettype wire

// File: rtl/pdm_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_skid_buf
//  Description : One-entry holding register for a PDM word that lost the
//                memory port to a host read. Clear beats load beats drain,
//                so a drain with a simultaneous load keeps the entry full.
//  Revision    : 1.0 - initial release
// ============================================================================
module pdm_skid_buf
  import pdm_pkg::*;
#(
  parameter int DW = PDM_DW
) (
  input  logic          ahb_clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic          drain,
  input  logic [DW-1:0] load_data,
  output logic          full,
  output logic [DW-1:0] data
);

  // Entry occupancy and payload.
  always_ff @(posedge ahb_clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (clr) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule : pdm_skid_buf
`default_nettype wire

// File: rtl/pdm_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_mem_arb
//  Description : Shares one synchronous-read memory port between a PDM
//                capture stream and host reads. A pending buffered word
//                always wins, then a host read, then a fresh capture word.
//                Optional build macro PDM_ARB_RDSTALL_CNT_EN adds a 16-bit
//                saturating count of stalled host-read cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module pdm_mem_arb
  import pdm_pkg::*;
#(
  parameter int DEPTH = PDM_DEPTH,
  parameter int AW    = PDM_AW,
  parameter int DW    = PDM_DW
) (
  input  logic          ahb_clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          word_valid,
  input  logic [DW-1:0] word_data,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic          rd_rvalid,
  output logic [DW-1:0] rd_data,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          bsy,
  output logic          done,
  output logic [AW:0]   wcount
`ifdef PDM_ARB_RDSTALL_CNT_EN
  ,
  output logic [15:0]   rd_stall_cnt
`endif
);

  localparam logic [AW:0] LAST_WR = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

  pdm_state_e    state;
  pdm_state_e    state_nxt;
  logic          in_cap;
  logic          abort_cap;
  logic          start_ok;
  logic          wv_cap;
  logic          sel_buf;
  logic          sel_rd;
  logic          sel_word;
  logic          wr_commit;
  logic          last_wr;
  logic          buf_full;
  logic [DW-1:0] buf_data;

  // An abort in CAPTURE suppresses every capture write that cycle, so a
  // word sitting in the buffer is discarded rather than committed.
  assign in_cap    = (state == ST_CAPTURE);
  assign abort_cap = abort & in_cap;
  assign start_ok  = start & ~in_cap;
  assign wv_cap    = word_valid & in_cap & ~abort_cap;
  assign sel_buf   = buf_full & ~abort_cap;
  assign sel_rd    = ~sel_buf & rd_req;
  assign sel_word  = ~sel_buf & ~rd_req & wv_cap;
  assign wr_commit = sel_buf | sel_word;
  assign last_wr   = wr_commit & (wcount == LAST_WR);
  assign bsy       = in_cap;

  pdm_skid_buf #(
    .DW(DW)
  ) u_skid (
    .ahb_clk  (ahb_clk),
    .rst      (rst),
    .clr      (start_ok | abort_cap | last_wr),
    .load     (wv_cap & (sel_buf | sel_rd)),
    .drain    (sel_buf),
    .load_data(word_data),
    .full     (buf_full),
    .data     (buf_data)
  );

  // Capture state register.
  always_ff @(posedge ahb_clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: start leaves IDLE/DONE, abort or the final write leaves CAPTURE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        if (abort)        state_nxt = ST_IDLE;
        else if (last_wr) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Port grant and memory drive; everything is forced quiet while in reset.
  always_comb begin
    rd_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = rd_addr;
    mem_wdata = word_data;
    rd_data   = '0;
    if (!rst) begin
      rd_gnt = sel_rd;
      mem_en = sel_rd | wr_commit;
      mem_we = wr_commit;
      if (wr_commit) mem_addr = wcount[AW-1:0];
      if (sel_buf)   mem_wdata = buf_data;
    end
    if (rd_rvalid) rd_data = mem_rdata;
  end

  // Committed-word count and completion flag.
  always_ff @(posedge ahb_clk or posedge rst) begin
    if (rst) begin
      wcount <= '0;
      done   <= 1'b0;
    end else if (start_ok) begin
      wcount <= '0;
      done   <= 1'b0;
    end else if (wr_commit) begin
      wcount <= wcount + ONE;
      if (last_wr) done <= 1'b1;
    end
  end

  // Read data is valid the cycle after the grant (memory read latency).
  always_ff @(posedge ahb_clk or posedge rst) begin
    if (rst) rd_rvalid <= 1'b0;
    else     rd_rvalid <= sel_rd;
  end

`ifdef PDM_ARB_RDSTALL_CNT_EN
  // Saturating count of cycles a host read waited behind the buffer.
  always_ff @(posedge ahb_clk or posedge rst) begin
    if (rst)                                           rd_stall_cnt <= '0;
    else if (start_ok)                                 rd_stall_cnt <= '0;
    else if (rd_req && !rd_gnt && rd_stall_cnt != 16'hFFFF) rd_stall_cnt <= rd_stall_cnt + 16'd1;
  end
`endif

endmodule : pdm_mem_arb
`default_nettype wire
